// File: rtl/ntt_core_gf64_pkg.sv
// Shared GF64 (Goldilocks) definitions for the NTT core: prime builder,
// candidate offsets used by the final reduction, and the candidate word type.
package ntt_core_gf64_pkg;

    // Widest field the candidate type can hold
    localparam int GF64_MAX_W = 64;

    // Number of candidates a + k*p examined by the final reduction
    localparam int GF64_CAND_NB = 6;

    // Offsets k, largest first, so the flags form a thermometer over the index
    localparam int GF64_CAND_OFS [GF64_CAND_NB] = '{3, 2, 1, 0, -1, -2};

    // Signed candidate word: W bits of field plus headroom for sign and 3p
    typedef logic signed [GF64_MAX_W+3:0] gf64_cand_t;

    // p = 2**w - 2**(w/2) + 1, returned on the widest candidate width
    function automatic gf64_cand_t gf64_prime(input int w);
        gf64_cand_t one;
        one = gf64_cand_t'(1);
        return (one << w) - (one << (w / 2)) + one;
    endfunction

    // k*p as a signed candidate word
    function automatic gf64_cand_t gf64_cand_offset(input int w, input int k);
        return gf64_cand_t'(k) * gf64_prime(w);
    endfunction

endpackage

// File: rtl/ntt_core_gf64_cand_sel.sv
// Picks the one candidate that lies in [0, p-1] given its neg/ge flags.
// Because the candidates are ordered by decreasing offset, ge is a run of ones
// followed by zeros and neg a run of zeros followed by ones, so exactly one
// index has both flags clear and a one-hot AND-OR mux is enough.
module ntt_core_gf64_cand_sel
    import ntt_core_gf64_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [GF64_CAND_NB-1:0]        neg,
    input  logic [GF64_CAND_NB-1:0]        ge,
    input  logic [GF64_CAND_NB-1:0][W-1:0] cand,
    output logic [W-1:0]                   z
);

    logic [GF64_CAND_NB-1:0] onehot;

    assign onehot = ~neg & ~ge;

    // One-hot AND-OR mux over the candidate low words
    always_comb begin
        z = '0;
        for (int i = 0; i < GF64_CAND_NB; i++) begin
            z = z | (cand[i] & {W{onehot[i]}});
        end
    end

endmodule

// File: rtl/ntt_core_gf64_final_reduction.sv
// Canonical reduction of a signed (W+2)-bit partial result into [0, p-1]
// for the Goldilocks prime. Streaming, one sample per cycle, latency IN_PIPE+2.
module ntt_core_gf64_final_reduction
    import ntt_core_gf64_pkg::*;
#(
    parameter int         MOD_NTT_W = 64,
    parameter int         IN_PIPE   = 1,
    parameter int         SIDE_W    = 0,
    parameter logic [1:0] RST_SIDE  = 2'b00
) (
    input  logic                                  clk,
    input  logic                                  s_rst,
    input  logic [MOD_NTT_W+1:0]                  a,
    input  logic                                  in_avail,
    input  logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] in_side,
    output logic [MOD_NTT_W-1:0]                  z,
    output logic                                  out_avail,
    output logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] out_side
);

    localparam int W  = MOD_NTT_W;
    localparam int CW = W + 4;
    localparam int SW = (SIDE_W > 0) ? SIDE_W : 1;

    localparam gf64_cand_t              P_FULL        = gf64_prime(W);
    localparam logic signed [CW-1:0]    P             = P_FULL[CW-1:0];
    localparam bit                      SIDE_HAS_RST  = (RST_SIDE != 2'b00);
    localparam logic [SW-1:0]           SIDE_RST_VAL  = RST_SIDE[1] ? {SW{1'b1}} : {SW{1'b0}};

    if ((W % 2) != 0 || W < 4 || W > GF64_MAX_W) begin : g_bad_width
        $fatal(1, "ntt_core_gf64_final_reduction: MOD_NTT_W must be even and in [4, 64]");
    end

    logic [W+1:0]  s0_a;
    logic          s0_avail;
    logic [SW-1:0] s0_side;

    if (IN_PIPE != 0) begin : g_in_pipe
        // Input data register, free running
        always_ff @(posedge clk) begin
            s0_a <= a;
        end

        // Input avail register, cleared by reset so samples seen in reset are dropped
        always_ff @(posedge clk) begin
            if (s_rst) s0_avail <= 1'b0;
            else       s0_avail <= in_avail;
        end

        // Input side register with optional reset value
        always_ff @(posedge clk) begin
            if (s_rst && SIDE_HAS_RST) s0_side <= SIDE_RST_VAL;
            else                       s0_side <= in_side;
        end
    end else begin : g_in_comb
        assign s0_a     = a;
        assign s0_avail = in_avail;
        assign s0_side  = in_side;
    end

    // Stage s1: candidates a + k*p and their range flags
    logic signed [CW-1:0] a_ext;
    logic signed [CW-1:0] cand [GF64_CAND_NB];

    assign a_ext = {{2{s0_a[W+1]}}, s0_a};

    for (genvar i = 0; i < GF64_CAND_NB; i++) begin : g_cand
        localparam gf64_cand_t           OFS_FULL = gf64_cand_offset(W, GF64_CAND_OFS[i]);
        localparam logic signed [CW-1:0] OFS      = OFS_FULL[CW-1:0];
        assign cand[i] = a_ext + OFS;
    end

    logic [GF64_CAND_NB-1:0]        s1_neg;
    logic [GF64_CAND_NB-1:0]        s1_ge;
    logic [GF64_CAND_NB-1:0][W-1:0] s1_low;
    logic                           s1_avail;
    logic [SW-1:0]                  s1_side;

    // Register per-candidate flags and low words
    always_ff @(posedge clk) begin
        for (int i = 0; i < GF64_CAND_NB; i++) begin
            s1_neg[i] <= cand[i][CW-1];
            s1_ge[i]  <= (cand[i] >= P);
            s1_low[i] <= cand[i][W-1:0];
        end
    end

    // s1 avail and side delay
    always_ff @(posedge clk) begin
        if (s_rst) s1_avail <= 1'b0;
        else       s1_avail <= s0_avail;
        if (s_rst && SIDE_HAS_RST) s1_side <= SIDE_RST_VAL;
        else                       s1_side <= s0_side;
    end

    // Stage s2: select the in-range candidate
    logic [W-1:0] sel_z;

    ntt_core_gf64_cand_sel #(
        .W (W)
    ) u_cand_sel (
        .neg  (s1_neg),
        .ge   (s1_ge),
        .cand (s1_low),
        .z    (sel_z)
    );

    // Output data register, free running
    always_ff @(posedge clk) begin
        z <= sel_z;
    end

    // Output avail and side delay
    always_ff @(posedge clk) begin
        if (s_rst) out_avail <= 1'b0;
        else       out_avail <= s1_avail;
        if (s_rst && SIDE_HAS_RST) out_side <= SIDE_RST_VAL;
        else                       out_side <= s1_side;
    end

endmodule
